// File: rtl/e203_exu_regfile_mp_pkg.sv
// Shared constants for the multi-port EXU register file.
// No logic here. There is no latency.
// No handshake. These are the build defaults and the init-FSM state encodings.
package e203_exu_regfile_mp_pkg;

    // Build-time defaults for the regfile configuration
    localparam int E203_RF_NRD         = 2;
    localparam int E203_RF_BYPASS      = 1;
    localparam int E203_RF_RESET_SWEEP = 0;

    // Init FSM state encodings; kept as 1-bit constants for legacy tooling
    localparam logic [0:0] RF_ST_SWEEP = 1'b0;
    localparam logic [0:0] RF_ST_READY = 1'b1;

endpackage

// File: rtl/e203_exu_rf_sbd.sv
// Pending scoreboard for outstanding long-pipe writebacks, with one bit per GPR (x1..xN-1).
// Latency: a set or clear takes effect one clock after it is presented. o_any is combinational from the state.
// Backpressure: none. i_en=0 freezes the vector, which happens while the regfile is still initialising.
//
// Ports: i_clk/i_rst (async, active-high), i_en, i_set/i_set_idx (mark pending),
//        i_clr/i_clr_idx (long-pipe writeback), o_pend[NREG-1:1], o_any (OR of all bits).
module e203_exu_rf_sbd #(
    parameter int NREG = 32,
    parameter int IDXW = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_set,
    input  logic [IDXW-1:0] i_set_idx,
    input  logic            i_clr,
    input  logic [IDXW-1:0] i_clr_idx,
    output logic [NREG-1:1] o_pend,
    output logic            o_any
);

    // x0 has no bit, so a set aimed at x0 simply has nowhere to land
    for (genvar g = 1; g < NREG; g++) begin : g_pend
        localparam logic [IDXW-1:0] L_IDX = IDXW'(g);
        logic r_pend;

        // Set is checked first: a new dispatch to a register whose older op
        // retires in the same cycle must keep the register pending.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_pend <= 1'b0;
            end else if (i_en) begin
                if (i_set && (i_set_idx == L_IDX)) begin
                    r_pend <= 1'b1;
                end else if (i_clr && (i_clr_idx == L_IDX)) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign o_pend[g] = r_pend;
    end

    assign o_any = |o_pend;

endmodule

// File: rtl/e203_exu_regfile_mp.sv
// Multi-port GPR file. It has NRD combinational read ports, an ALU write port (0), a long-pipe write port (1),
// a pending scoreboard, optional write-to-read bypass and an optional post-reset zeroing sweep.
// Latency: reads are combinational and writes land at the next clock. Backpressure: o_rf_ready low means dispatch stalls.
//
// Ports: i_clk, i_rst (async, active-high), o_rf_ready, i_rd_idx/o_rd_dat/o_rd_busy (NRD packed ports),
//        i_wen0/i_widx0/i_wdat0, i_wen1/i_widx1/i_wdat1 (also clears pending), i_sb_set/i_sb_idx,
//        o_sb_any (drain indication), o_x1_r (raw storage view of x1 for the IFU).
module e203_exu_regfile_mp
    import e203_exu_regfile_mp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int IDXW        = 5,
    parameter int NRD         = E203_RF_NRD,
    parameter int BYPASS      = E203_RF_BYPASS,
    parameter int RESET_SWEEP = E203_RF_RESET_SWEEP
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_rf_ready,
    input  logic [NRD*IDXW-1:0]  i_rd_idx,
    output logic [NRD*XLEN-1:0]  o_rd_dat,
    output logic [NRD-1:0]       o_rd_busy,
    input  logic                 i_wen0,
    input  logic [IDXW-1:0]      i_widx0,
    input  logic [XLEN-1:0]      i_wdat0,
    input  logic                 i_wen1,
    input  logic [IDXW-1:0]      i_widx1,
    input  logic [XLEN-1:0]      i_wdat1,
    input  logic                 i_sb_set,
    input  logic [IDXW-1:0]      i_sb_idx,
    output logic                 o_sb_any,
    output logic [XLEN-1:0]      o_x1_r
);

    localparam logic [IDXW-1:0] L_LAST   = IDXW'(NREG - 1);
    localparam logic [0:0]      L_RST_ST = (RESET_SWEEP != 0) ? RF_ST_SWEEP : RF_ST_READY;

    logic [0:0]      r_state;
    logic [IDXW-1:0] r_cnt;
    logic            w_ready;
    logic [XLEN-1:0] w_regs [1:NREG-1];
    logic [NREG-1:1] w_pend;

    // ------------------------------------------------------------------
    // Init FSM. Without the sweep it comes out of reset already in READY.
    // With the sweep, r_cnt walks x1..xN-1 and writes one register per cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= L_RST_ST;
            r_cnt   <= IDXW'(1);
        end else if (r_state == RF_ST_SWEEP) begin
            r_cnt <= r_cnt + IDXW'(1);
            if (r_cnt == L_LAST) begin
                r_state <= RF_ST_READY;
            end
        end
    end

    assign w_ready    = (r_state == RF_ST_READY);
    assign o_rf_ready = w_ready;

    // ------------------------------------------------------------------
    // Storage for x1..xN-1. x0 is never stored.
    // ------------------------------------------------------------------
    for (genvar g = 1; g < NREG; g++) begin : g_reg
        localparam logic [IDXW-1:0] L_IDX = IDXW'(g);
        logic            w_hit0;
        logic            w_hit1;
        logic            w_we;
        logic [XLEN-1:0] w_wd;
        logic [XLEN-1:0] r_q;

        assign w_hit0 = i_wen0 && (i_widx0 == L_IDX);
        assign w_hit1 = i_wen1 && (i_widx1 == L_IDX);
        // During the sweep both write ports are locked out and only the
        // sweep pointer can write, and it always writes zero.
        // On a collision port 0 wins because it belongs to the younger instruction.
        assign w_we   = w_ready ? (w_hit0 || w_hit1) : (r_cnt == L_IDX);
        assign w_wd   = !w_ready ? '0 : (w_hit0 ? i_wdat0 : i_wdat1);

        if (RESET_SWEEP != 0) begin : g_nrst
            always_ff @(posedge i_clk) begin
                if (w_we) begin
                    r_q <= w_wd;
                end
            end
        end else begin : g_rst
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_q <= '0;
                end else if (w_we) begin
                    r_q <= w_wd;
                end
            end
        end

        assign w_regs[g] = r_q;
    end

    // ------------------------------------------------------------------
    // Pending scoreboard. It is frozen while sweeping so that dispatch noise is ignored.
    // ------------------------------------------------------------------
    e203_exu_rf_sbd #(
        .NREG (NREG),
        .IDXW (IDXW)
    ) u_sbd (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (w_ready),
        .i_set     (i_sb_set),
        .i_set_idx (i_sb_idx),
        .i_clr     (i_wen1),
        .i_clr_idx (i_widx1),
        .o_pend    (w_pend),
        .o_any     (o_sb_any)
    );

    // ------------------------------------------------------------------
    // Read ports. Only indices 1..NREG-1 can match. x0, out-of-range indices
    // and the whole sweep period therefore fall through to zero / not busy.
    // ------------------------------------------------------------------
    always_comb begin
        o_rd_dat  = '0;
        o_rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            for (int i = 1; i < NREG; i++) begin
                if (w_ready && (i_rd_idx[k*IDXW +: IDXW] == IDXW'(i))) begin
                    o_rd_dat[k*XLEN +: XLEN] = w_regs[i];
                    o_rd_busy[k]             = w_pend[i];
                    if (BYPASS != 0) begin
                        if (i_wen0 && (i_widx0 == IDXW'(i))) begin
                            o_rd_dat[k*XLEN +: XLEN] = i_wdat0;
                        end else if (i_wen1 && (i_widx1 == IDXW'(i))) begin
                            o_rd_dat[k*XLEN +: XLEN] = i_wdat1;
                        end
                        // The retiring long-pipe result is forwarded right now,
                        // so the consumer does not need to wait for it.
                        if (i_wen1 && (i_widx1 == IDXW'(i))) begin
                            o_rd_busy[k] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Link-register path wants the committed value, never a forwarded one
    assign o_x1_r = w_regs[1];

endmodule

// File: tb/tb_e203_exu_regfile_mp.sv
// Bench for e203_exu_regfile_mp. It runs two builds side by side on shared stimulus.
// Build 0 uses 32 regs with bypass and the reset sweep. Build 1 uses 16 regs, no bypass and reset storage.
// Checks are made #1-#2 after the rising edge, against a behavioural array/counter reference model.
module tb_e203_exu_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_idx;
    logic        wen0;
    logic [4:0]  widx0;
    logic [31:0] wdat0;
    logic        wen1;
    logic [4:0]  widx1;
    logic [31:0] wdat1;
    logic        sb_set;
    logic [4:0]  sb_idx;

    logic        o0_rf_ready, o1_rf_ready;
    logic [63:0] o0_rd_dat,   o1_rd_dat;
    logic [1:0]  o0_rd_busy,  o1_rd_busy;
    logic        o0_sb_any,   o1_sb_any;
    logic [31:0] o0_x1_r,     o1_x1_r;

    int n_tests = 0;
    int n_fail  = 0;

    e203_exu_regfile_mp #(
        .XLEN(32), .NREG(32), .IDXW(5), .NRD(2), .BYPASS(1), .RESET_SWEEP(1)
    ) u_dut_sw (
        .i_clk(clk), .i_rst(rst), .o_rf_ready(o0_rf_ready),
        .i_rd_idx(rd_idx), .o_rd_dat(o0_rd_dat), .o_rd_busy(o0_rd_busy),
        .i_wen0(wen0), .i_widx0(widx0), .i_wdat0(wdat0),
        .i_wen1(wen1), .i_widx1(widx1), .i_wdat1(wdat1),
        .i_sb_set(sb_set), .i_sb_idx(sb_idx), .o_sb_any(o0_sb_any), .o_x1_r(o0_x1_r)
    );

    e203_exu_regfile_mp #(
        .XLEN(32), .NREG(16), .IDXW(5), .NRD(2), .BYPASS(0), .RESET_SWEEP(0)
    ) u_dut_nb (
        .i_clk(clk), .i_rst(rst), .o_rf_ready(o1_rf_ready),
        .i_rd_idx(rd_idx), .o_rd_dat(o1_rd_dat), .o_rd_busy(o1_rd_busy),
        .i_wen0(wen0), .i_widx0(widx0), .i_wdat0(wdat0),
        .i_wen1(wen1), .i_widx1(widx1), .i_wdat1(wdat1),
        .i_sb_set(sb_set), .i_sb_idx(sb_idx), .o_sb_any(o1_sb_any), .o_x1_r(o1_x1_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-build views so the random checker can loop over both
    logic        rdy_v  [2];
    logic [63:0] dat_v  [2];
    logic [1:0]  busy_v [2];
    logic        any_v  [2];
    logic [31:0] x1_v   [2];
    assign rdy_v[0]  = o0_rf_ready; assign rdy_v[1]  = o1_rf_ready;
    assign dat_v[0]  = o0_rd_dat;   assign dat_v[1]  = o1_rd_dat;
    assign busy_v[0] = o0_rd_busy;  assign busy_v[1] = o1_rd_busy;
    assign any_v[0]  = o0_sb_any;   assign any_v[1]  = o1_sb_any;
    assign x1_v[0]   = o0_x1_r;     assign x1_v[1]   = o1_x1_r;

    // ---------------- reference model ----------------
    logic [31:0] m_reg   [2][32];
    bit          m_pend  [2][32];
    int          m_sweep [2];      // cycles of init still to go; 0 = ready

    function automatic int m_nreg(int d);
        return (d == 0) ? 32 : 16;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) m_pend[d][i] = 1'b0;
        for (int i = 0; i < 32; i++) m_reg[1][i] = '0;
        m_sweep[0] = 31;
        m_sweep[1] = 0;
    endfunction

    function automatic logic [31:0] m_rd(int d, logic [4:0] idx);
        if (m_sweep[d] > 0 || idx == 0 || int'(idx) >= m_nreg(d)) return '0;
        if (d == 0 && wen0 && widx0 == idx) return wdat0;
        if (d == 0 && wen1 && widx1 == idx) return wdat1;
        return m_reg[d][idx];
    endfunction

    function automatic logic m_busy(int d, logic [4:0] idx);
        if (m_sweep[d] > 0 || idx == 0 || int'(idx) >= m_nreg(d)) return 1'b0;
        if (d == 0 && wen1 && widx1 == idx) return 1'b0;
        return m_pend[d][idx];
    endfunction

    function automatic logic m_any(int d);
        logic a = 1'b0;
        for (int i = 0; i < 32; i++) a = a | m_pend[d][i];
        return a;
    endfunction

    // Applies the current inputs as the upcoming clock edge would
    function automatic void m_edge();
        for (int d = 0; d < 2; d++) begin
            int n = m_nreg(d);
            if (m_sweep[d] > 0) begin
                m_sweep[d]--;
                if (m_sweep[d] == 0)
                    for (int i = 0; i < 32; i++) m_reg[d][i] = '0;
            end else begin
                if (wen1 && widx1 != 0 && int'(widx1) < n) begin
                    m_reg[d][widx1]  = wdat1;
                    m_pend[d][widx1] = 1'b0;
                end
                if (wen0 && widx0 != 0 && int'(widx0) < n) m_reg[d][widx0] = wdat0;
                if (sb_set && sb_idx != 0 && int'(sb_idx) < n) m_pend[d][sb_idx] = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        m_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wen0 = 0; widx0 = 0; wdat0 = 0;
        wen1 = 0; widx1 = 0; wdat1 = 0;
        sb_set = 0; sb_idx = 0; rd_idx = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int low;
        rst = 1'b1;
        idle();
        rd_idx = {5'd1, 5'd5};
        @(posedge clk); @(posedge clk); #2;
        model_reset();
        n_tests++; if (o0_rf_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready0 got %b exp 0", o0_rf_ready); end
        n_tests++; if (o0_sb_any !== 1'b0)   begin n_fail++; $display("FAIL rst_any0 got %b exp 0", o0_sb_any); end
        n_tests++; if (o1_sb_any !== 1'b0)   begin n_fail++; $display("FAIL rst_any1 got %b exp 0", o1_sb_any); end
        n_tests++; if (o1_rd_dat !== 64'h0)  begin n_fail++; $display("FAIL rst_dat1 got %h exp 0", o1_rd_dat); end
        rst = 1'b0;
        #1;
        n_tests++; if (o1_rf_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready1 got %b exp 1", o1_rf_ready); end
        // Hammer x5 with writes and dispatches during the sweep
        wen0 = 1; widx0 = 5; wdat0 = 32'h55; sb_set = 1; sb_idx = 5;
        low = 0;
        while (o0_rf_ready !== 1'b1 && low < 100) begin
            n_tests++;
            if (o0_rd_dat !== 64'h0 || o0_rd_busy !== 2'b00) begin
                n_fail++; $display("FAIL sweep_rd cyc%0d got %h/%b exp 0/00", low, o0_rd_dat, o0_rd_busy);
            end
            low++;
            tick();
        end
        n_tests++; if (low != 31) begin n_fail++; $display("FAIL sweep_len got %0d exp 31", low); end
        idle();
        rd_idx = {5'd1, 5'd5};
        #1;
        n_tests++; if (o0_rd_dat[31:0] !== 32'h0) begin n_fail++; $display("FAIL sweep_x5 got %h exp 0", o0_rd_dat[31:0]); end
        n_tests++; if (o0_sb_any !== 1'b0) begin n_fail++; $display("FAIL sweep_any got %b exp 0", o0_sb_any); end
        n_tests++; if (o1_rd_dat[31:0] !== 32'h55 || o1_rd_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL nb_x5 got %h/%b exp 55/1", o1_rd_dat[31:0], o1_rd_busy[0]);
        end
        wen1 = 1; widx1 = 5; wdat1 = 32'h55;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        wen0 = 1; widx0 = 3; wdat0 = 32'h1234;
        tick();
        wen0 = 1; widx0 = 3; wdat0 = 32'hDEADBEEF; rd_idx = {5'd0, 5'd3};
        #1;
        n_tests++; if (o0_rd_dat[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL byp_same got %h exp deadbeef", o0_rd_dat[31:0]); end
        n_tests++; if (o1_rd_dat[31:0] !== 32'h1234)     begin n_fail++; $display("FAIL nobyp_same got %h exp 1234", o1_rd_dat[31:0]); end
        tick();
        wen0 = 0;
        #1;
        n_tests++; if (o0_rd_dat[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL byp_next got %h exp deadbeef", o0_rd_dat[31:0]); end
        n_tests++; if (o1_rd_dat[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nobyp_next got %h exp deadbeef", o1_rd_dat[31:0]); end
        idle();
    endtask

    task automatic test_dual_write();
        sb_set = 1; sb_idx = 7;
        tick();
        idle();
        rd_idx = {5'd7, 5'd7};
        #1;
        n_tests++; if (o0_rd_busy !== 2'b11 || o1_rd_busy !== 2'b11) begin
            n_fail++; $display("FAIL dual_pend got %b/%b exp 11/11", o0_rd_busy, o1_rd_busy);
        end
        wen0 = 1; widx0 = 7; wdat0 = 32'h11;
        wen1 = 1; widx1 = 7; wdat1 = 32'h22;
        #1;
        n_tests++; if (o0_rd_dat !== {32'h11, 32'h11}) begin n_fail++; $display("FAIL dual_byp got %h exp 11 both", o0_rd_dat); end
        n_tests++; if (o0_rd_busy !== 2'b00 || o1_rd_busy !== 2'b11) begin
            n_fail++; $display("FAIL dual_busy got %b/%b exp 00/11", o0_rd_busy, o1_rd_busy);
        end
        tick();
        wen0 = 0; wen1 = 0;
        #1;
        n_tests++; if (o0_rd_dat[31:0] !== 32'h11 || o1_rd_dat[31:0] !== 32'h11) begin
            n_fail++; $display("FAIL dual_store got %h/%h exp 11/11", o0_rd_dat[31:0], o1_rd_dat[31:0]);
        end
        n_tests++; if (o0_sb_any !== 1'b0 || o1_sb_any !== 1'b0 || o1_rd_busy !== 2'b00) begin
            n_fail++; $display("FAIL dual_clr got %b/%b/%b exp 0/0/00", o0_sb_any, o1_sb_any, o1_rd_busy);
        end
        idle();
    endtask

    task automatic test_scoreboard();
        sb_set = 1; sb_idx = 9;
        tick();
        idle();
        rd_idx = {5'd0, 5'd9};
        #1;
        n_tests++; if (o0_rd_busy[0] !== 1'b1 || o1_rd_busy[0] !== 1'b1 || o0_sb_any !== 1'b1 || o1_sb_any !== 1'b1) begin
            n_fail++; $display("FAIL sb_set got %b%b%b%b exp 1111", o0_rd_busy[0], o1_rd_busy[0], o0_sb_any, o1_sb_any);
        end
        sb_set = 1; sb_idx = 9; wen1 = 1; widx1 = 9; wdat1 = 32'h99;
        #1;
        n_tests++; if (o0_rd_busy[0] !== 1'b0 || o1_rd_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL sb_clrbyp got %b/%b exp 0/1", o0_rd_busy[0], o1_rd_busy[0]);
        end
        tick();
        sb_set = 0; wen1 = 0;
        #1;
        n_tests++; if (o0_rd_busy[0] !== 1'b1 || o1_rd_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL sb_setwins got %b/%b exp 1/1", o0_rd_busy[0], o1_rd_busy[0]);
        end
        wen1 = 1; widx1 = 9; wdat1 = 32'h99;
        tick();
        wen1 = 0;
        #1;
        n_tests++; if (o0_rd_busy[0] !== 1'b0 || o1_rd_busy[0] !== 1'b0 || o0_sb_any !== 1'b0 || o1_sb_any !== 1'b0) begin
            n_fail++; $display("FAIL sb_clear got %b%b%b%b exp 0000", o0_rd_busy[0], o1_rd_busy[0], o0_sb_any, o1_sb_any);
        end
        n_tests++; if (o0_rd_dat[31:0] !== 32'h99 || o1_rd_dat[31:0] !== 32'h99) begin
            n_fail++; $display("FAIL sb_data got %h/%h exp 99/99", o0_rd_dat[31:0], o1_rd_dat[31:0]);
        end
        idle();
    endtask

    task automatic test_x0_and_range();
        wen0 = 1; widx0 = 0; wdat0 = 32'hFFFFFFFF; sb_set = 1; sb_idx = 0; rd_idx = {5'd0, 5'd0};
        #1;
        n_tests++; if (o0_rd_dat !== 64'h0 || o0_rd_busy !== 2'b00) begin
            n_fail++; $display("FAIL x0_same got %h/%b exp 0/00", o0_rd_dat, o0_rd_busy);
        end
        tick();
        idle();
        #1;
        n_tests++; if (o0_rd_dat !== 64'h0 || o1_rd_dat !== 64'h0 || o0_sb_any !== 1'b0 || o1_sb_any !== 1'b0) begin
            n_fail++; $display("FAIL x0_after got %h/%h/%b/%b exp 0", o0_rd_dat, o1_rd_dat, o0_sb_any, o1_sb_any);
        end
        // Index 20 exists in the 32-entry build only
        wen0 = 1; widx0 = 20; wdat0 = 32'hABCD; sb_set = 1; sb_idx = 20;
        tick();
        idle();
        rd_idx = {5'd0, 5'd20};
        #1;
        n_tests++; if (o0_rd_dat[31:0] !== 32'hABCD || o0_rd_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL r20_sw got %h/%b exp abcd/1", o0_rd_dat[31:0], o0_rd_busy[0]);
        end
        n_tests++; if (o1_rd_dat[31:0] !== 32'h0 || o1_rd_busy[0] !== 1'b0 || o1_sb_any !== 1'b0) begin
            n_fail++; $display("FAIL r20_nb got %h/%b/%b exp 0/0/0", o1_rd_dat[31:0], o1_rd_busy[0], o1_sb_any);
        end
        wen1 = 1; widx1 = 20; wdat1 = 32'hABCD;
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            wen0   = ($urandom_range(0, 1) == 1);
            widx0  = 5'($urandom_range(0, 31));
            wdat0  = $urandom();
            wen1   = ($urandom_range(0, 2) == 0);
            widx1  = 5'($urandom_range(0, 31));
            wdat1  = $urandom();
            sb_set = ($urandom_range(0, 2) == 0);
            sb_idx = 5'($urandom_range(0, 31));
            rd_idx[4:0] = ($urandom_range(0, 1) == 1) ? widx0 : 5'($urandom_range(0, 31));
            rd_idx[9:5] = ($urandom_range(0, 1) == 1) ? widx1 : 5'($urandom_range(0, 31));
            #1;
            for (int d = 0; d < 2; d++) begin
                n_tests++;
                if (rdy_v[d] !== (m_sweep[d] == 0)) begin
                    n_fail++; $display("FAIL rnd_ready d%0d cyc%0d got %b", d, c, rdy_v[d]);
                end
                for (int k = 0; k < 2; k++) begin
                    logic [31:0] ed;
                    logic        eb;
                    ed = m_rd(d, rd_idx[k*5 +: 5]);
                    eb = m_busy(d, rd_idx[k*5 +: 5]);
                    n_tests++;
                    if (dat_v[d][k*32 +: 32] !== ed) begin
                        n_fail++; $display("FAIL rnd_dat d%0d p%0d cyc%0d got %h exp %h", d, k, c, dat_v[d][k*32 +: 32], ed);
                    end
                    n_tests++;
                    if (busy_v[d][k] !== eb) begin
                        n_fail++; $display("FAIL rnd_busy d%0d p%0d cyc%0d got %b exp %b", d, k, c, busy_v[d][k], eb);
                    end
                end
                n_tests++;
                if (any_v[d] !== m_any(d)) begin
                    n_fail++; $display("FAIL rnd_any d%0d cyc%0d got %b exp %b", d, c, any_v[d], m_any(d));
                end
                n_tests++;
                if (x1_v[d] !== m_reg[d][1]) begin
                    n_fail++; $display("FAIL rnd_x1 d%0d cyc%0d got %h exp %h", d, c, x1_v[d], m_reg[d][1]);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_sweep_restart();
        int low;
        rst = 1'b1;
        idle();
        @(posedge clk); #2;
        model_reset();
        rst = 1'b0;
        // Only the non-sweep build takes this dispatch
        sb_set = 1; sb_idx = 4;
        tick();
        idle();
        for (int i = 0; i < 10; i++) tick();
        rd_idx = {5'd0, 5'd4};
        #1;
        n_tests++; if (o1_sb_any !== 1'b1 || o0_rf_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_pre got %b/%b exp 1/0", o1_sb_any, o0_rf_ready);
        end
        rst = 1'b1;
        #1;
        n_tests++; if (o0_rf_ready !== 1'b0 || o1_sb_any !== 1'b0 || o1_rd_busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst got %b/%b/%b exp 0/0/0", o0_rf_ready, o1_sb_any, o1_rd_busy[0]);
        end
        model_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        low = 0;
        while (o0_rf_ready !== 1'b1 && low < 100) begin
            low++;
            tick();
        end
        n_tests++; if (low != 31) begin n_fail++; $display("FAIL restart_len got %0d exp 31", low); end
        // Every register must have been zeroed, not just the ones touched before
        for (int i = 0; i < 32; i += 2) begin
            rd_idx = {5'(i + 1), 5'(i)};
            #1;
            n_tests++;
            if (o0_rd_dat !== 64'h0 || o1_rd_dat !== 64'h0) begin
                n_fail++; $display("FAIL swept_x%0d got %h/%h exp 0", i, o0_rd_dat, o1_rd_dat);
            end
        end
        n_tests++; if (o0_x1_r !== 32'h0) begin n_fail++; $display("FAIL swept_x1r got %h exp 0", o0_x1_r); end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_x0_and_range();
        test_random();
        test_sweep_restart();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
